// File: rtl/sequence_detector_1094.sv
// sequence_detector_1094
// Watches a serial stream of 4-bit digits, one per rising clock edge, and
// raises a one-cycle registered pulse when the consecutive digits 1,0,9,4
// have been received. Overlapping matches are detected.
//
// Ports
//   clock   in   1  system clock, rising-edge active
//   reset   in   1  synchronous active-high reset, has priority over number
//   number  in   4  input digit, sampled on the rising edge
//   pattern out  1  registered match pulse, high for the cycle after the
//                   edge that samples the final 4
module sequence_detector_1094 (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] number,
  output logic       pattern
);

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] D_ONE  = DIGIT_W'(1);
  localparam logic [DIGIT_W-1:0] D_ZERO = DIGIT_W'(0);
  localparam logic [DIGIT_W-1:0] D_NINE = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] D_FOUR = DIGIT_W'(4);

  // Progress through the target sequence: S1 "1", S2 "10", S3 "109", S4 "1094"
  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  state_t r_state;

  // Match FSM with the pulse registered alongside the state, so pattern
  // always equals (r_state == S4) and has no combinational path from number.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S0;
      pattern <= 1'b0;
    end else begin
      pattern <= (r_state == S3) && (number == D_FOUR);
      case (r_state)
        S0: r_state <= (number == D_ONE) ? S1 : S0;
        S1: begin
          if (number == D_ZERO)     r_state <= S2;
          else if (number == D_ONE) r_state <= S1;
          else                      r_state <= S0;
        end
        S2: begin
          if (number == D_NINE)     r_state <= S3;
          else if (number == D_ONE) r_state <= S1;
          else                      r_state <= S0;
        end
        S3: begin
          if (number == D_FOUR)     r_state <= S4;
          else if (number == D_ONE) r_state <= S1;
          else                      r_state <= S0;
        end
        S4: r_state <= (number == D_ONE) ? S1 : S0;
        // Unreachable encodings recover to idle
        default: r_state <= S0;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_detector_1094.sv
// Testbench for sequence_detector_1094: directed vector table plus a
// randomized stream, both checked against a last-four-digits history model.
module tb_sequence_detector_1094;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] number = 4'd0;
  logic       pattern;

  int n_checks = 0;
  int n_fails  = 0;

  sequence_detector_1094 dut (
    .clock   (clock),
    .reset   (reset),
    .number  (number),
    .pattern (pattern)
  );

  always #5 clock = ~clock;

  // Reference: a match means the last four digits accepted since reset
  // are exactly 1,0,9,4.
  int   hist[$];
  logic m_exp   = 1'b0;
  bit   m_valid = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      hist.delete();
      m_exp   = 1'b0;
      m_valid = 1'b1;
    end else begin
      hist.push_back(int'(number));
      if (hist.size() > 4) void'(hist.pop_front());
      m_exp = (hist.size() == 4) && hist[0] == 1 && hist[1] == 0 &&
              hist[2] == 9 && hist[3] == 4;
    end
  end

  // Mid-cycle check against the model
  always @(negedge clock) begin
    if (m_valid) begin
      n_checks++;
      if (pattern !== m_exp) begin
        n_fails++;
        $display("FAIL model_negedge t=%0t pattern=%b expected=%b", $time, pattern, m_exp);
      end
    end
  end

  typedef struct {
    logic       rst;
    logic [3:0] num;
    logic       exp;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input int num, input logic exp, input string tag);
    vec_t v;
    v.rst = rst; v.num = 4'(num); v.exp = exp; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic add_seq(input int d[], input int hit_idx, input string tag);
    foreach (d[i]) add(1'b0, d[i], (i == hit_idx), tag);
  endtask

  // Drive on the falling edge, compare shortly after the rising edge
  task automatic step(input logic rst, input logic [3:0] num, input logic exp, input string tag);
    @(negedge clock);
    reset  = rst;
    number = num;
    @(posedge clock);
    #1;
    n_checks++;
    if (pattern !== exp) begin
      n_fails++;
      $display("FAIL %s t=%0t rst=%b num=%0d pattern=%b expected=%b",
               tag, $time, rst, num, pattern, exp);
    end
    n_checks++;
    if (pattern !== m_exp) begin
      n_fails++;
      $display("FAIL model_%s t=%0t pattern=%b model=%b", tag, $time, pattern, m_exp);
    end
  endtask

  initial begin
    int stream[20] = '{7,5,1,0,9,4,1,0,9,4,3,1,0,9,2,1,0,9,4,8};
    int nm1[4]     = '{1,0,9,2};
    int nm2[5]     = '{1,0,3,9,4};
    int rs1[5]     = '{1,1,0,9,4};
    int rs2[6]     = '{1,0,1,0,9,4};
    int oor1[5]    = '{1,0,9,12,4};
    int oor2[5]    = '{1,15,0,9,4};
    int pre[3]     = '{1,0,9};

    // Reset held two cycles with a 4 on the input, then release
    add(1'b1, 4, 1'b0, "reset_hold");
    add(1'b1, 4, 1'b0, "reset_hold");
    add(1'b0, 4, 1'b0, "reset_release");
    // Reference stream, twice back to back
    for (int r = 0; r < 2; r++)
      foreach (stream[i])
        add(1'b0, stream[i], (i == 5 || i == 9 || i == 18), "stream");
    add_seq(nm1, -1, "near_miss_1092");
    add_seq(nm2, -1, "near_miss_10394");
    add_seq(rs1, 4, "restart_11094");
    add_seq(rs2, 5, "restart_101094");
    add_seq(oor1, -1, "out_of_range_12");
    add_seq(oor2, -1, "out_of_range_15");
    add_seq(pre, -1, "mid_reset_prefix");
    add(1'b1, 4, 1'b0, "mid_reset");
    add(1'b0, 4, 1'b0, "mid_reset_after");

    foreach (vecs[i]) step(vecs[i].rst, vecs[i].num, vecs[i].exp, vecs[i].tag);

    // Randomized stream biased toward sequence digits, occasional reset
    for (int c = 0; c < 3000; c++) begin
      int  r;
      logic [3:0] d;
      logic rs;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    d = 4'd1;
        2, 3:    d = 4'd0;
        4, 5:    d = 4'd9;
        6, 7:    d = 4'd4;
        default: d = 4'($urandom_range(0, 15));
      endcase
      rs = ($urandom_range(0, 63) == 0);
      @(negedge clock);
      reset  = rs;
      number = d;
    end
    @(negedge clock);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
